// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures ROM output into IF/ID, and
// handles stalls, branch redirects and halt draining.
//
// state  | meaning
// RUN    | fetching sequentially, one instruction per cycle
// DRAIN  | halt captured; PC frozen, bubbles fed until the halt commits
// HALTED | core stopped; only reset exits
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'd1,
  parameter logic [8:0] HALT_OP  = 9'b110111000,
  parameter logic [8:0] NOP_OP   = 9'b000000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       stall_i,
  input  logic       redirect_i,
  input  logic [7:0] redirect_pc_i,
  input  logic       halt_ack_i,
  input  logic [8:0] rom_instr_i,
  output logic [7:0] pc_o,
  output logic [8:0] if_instr_o,
  output logic [7:0] if_pc_o,
  output logic       if_valid_o,
  output logic       halted_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] pc_q;
  logic [8:0] if_instr_q;
  logic [7:0] if_pc_q;
  logic       if_valid_q;
  logic       halted_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_OP;
      if_pc_q    <= 8'd0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_i) begin
            pc_q       <= redirect_pc_i;
            if_instr_q <= NOP_OP;
            if_valid_q <= 1'b0;
          end else if (!stall_i) begin
            if_instr_q <= rom_instr_i;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            // The halt itself is a real instruction; PC stops on it.
            if (rom_instr_i == HALT_OP) begin
              state_q <= DRAIN;
            end else begin
              pc_q <= pc_q + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (halt_ack_i) begin
            state_q    <= HALTED;
            halted_q   <= 1'b1;
            if_instr_q <= NOP_OP;
            if_valid_q <= 1'b0;
          end else if (redirect_i) begin
            // Halt was on a mispredicted path; resume at the target.
            state_q    <= RUN;
            pc_q       <= redirect_pc_i;
            if_instr_q <= NOP_OP;
            if_valid_q <= 1'b0;
          end else if (!stall_i) begin
            if_instr_q <= NOP_OP;
            if_valid_q <= 1'b0;
          end
        end
        HALTED: begin
          if_valid_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign if_instr_o = if_instr_q;
  assign if_pc_o    = if_pc_q;
  assign if_valid_o = if_valid_q;
  assign halted_o   = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a ROM model feeds rom_instr from pc, and
// each step compares the fetch outputs against hand-derived values.
module tb_fetch_stage;

  localparam logic [8:0] HALT = 9'b110111000;
  localparam logic [8:0] NOP  = 9'b000000000;

  logic       clk = 1'b0;
  logic       reset, stall, redirect, halt_ack;
  logic [7:0] redirect_pc;
  logic [8:0] rom_instr;
  logic [7:0] pc;
  logic [8:0] if_instr;
  logic [7:0] if_pc;
  logic       if_valid, halted;

  logic [8:0] rom [0:255];
  int n_pass = 0;
  int n_total = 0;

  fetch_stage dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .halt_ack_i   (halt_ack),
    .rom_instr_i  (rom_instr),
    .pc_o         (pc),
    .if_instr_o   (if_instr),
    .if_pc_o      (if_pc),
    .if_valid_o   (if_valid),
    .halted_o     (halted)
  );

  always #5 clk = ~clk;

  assign rom_instr = rom[pc];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'((i * 3 + 7) % 512);
    rom[29] = HALT;

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; halt_ack = 1'b0;
    redirect_pc = 8'd0;
    step();
    step();
    check("rst_pc", pc, 1);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_valid", if_valid, 0);
    check("rst_halted", halted, 0);
    reset = 1'b0;

    // Sequential fetch: pc 1..5 captured in order
    for (int k = 1; k <= 5; k++) begin
      step();
      check("seq_pc", pc, k + 1);
      check("seq_if_pc", if_pc, k);
      check("seq_if_instr", if_instr, rom[k]);
      check("seq_if_valid", if_valid, 1);
    end

    // Stall for 3 cycles at pc=6
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", pc, 6);
      check("stall_if_pc", if_pc, 5);
      check("stall_if_instr", if_instr, rom[5]);
      check("stall_if_valid", if_valid, 1);
    end
    stall = 1'b0;
    step();
    check("unstall_pc", pc, 7);
    check("unstall_if_pc", if_pc, 6);
    check("unstall_if_instr", if_instr, rom[6]);

    for (int k = 0; k < 10; k++) step();
    check("run_to_17", pc, 17);

    // Redirect to 20
    redirect = 1'b1; redirect_pc = 8'd20;
    step();
    redirect = 1'b0;
    check("redir_pc", pc, 20);
    check("redir_if_valid", if_valid, 0);
    check("redir_if_instr", if_instr, NOP);
    step();
    check("redir_tgt_if_pc", if_pc, 20);
    check("redir_tgt_if_valid", if_valid, 1);
    check("redir_tgt_if_instr", if_instr, rom[20]);
    check("redir_tgt_pc", pc, 21);

    // Redirect with simultaneous stall behaves identically
    redirect = 1'b1; stall = 1'b1; redirect_pc = 8'd20;
    step();
    redirect = 1'b0; stall = 1'b0;
    check("redst_pc", pc, 20);
    check("redst_if_valid", if_valid, 0);
    step();
    check("redst_tgt_if_pc", if_pc, 20);
    check("redst_tgt_if_valid", if_valid, 1);
    check("redst_tgt_pc", pc, 21);

    for (int k = 0; k < 8; k++) step();
    check("run_to_29", pc, 29);

    // Halt captured, then bubbles while pc holds
    step();
    check("halt_if_instr", if_instr, HALT);
    check("halt_if_pc", if_pc, 29);
    check("halt_if_valid", if_valid, 1);
    check("halt_pc", pc, 29);
    step();
    check("drain_if_instr", if_instr, NOP);
    check("drain_if_valid", if_valid, 0);
    check("drain_pc", pc, 29);
    check("drain_halted", halted, 0);

    // Wrong-path halt: redirect in DRAIN returns to RUN
    redirect = 1'b1; redirect_pc = 8'd4;
    step();
    redirect = 1'b0;
    check("wp_pc", pc, 4);
    check("wp_if_valid", if_valid, 0);
    check("wp_halted", halted, 0);
    step();
    check("wp_run_pc", pc, 5);
    check("wp_run_if_pc", if_pc, 4);
    check("wp_run_if_valid", if_valid, 1);
    check("wp_run_if_instr", if_instr, rom[4]);

    // Re-enter the halt and let it commit
    redirect = 1'b1; redirect_pc = 8'd29;
    step();
    redirect = 1'b0;
    check("rehalt_pc", pc, 29);
    step();
    check("rehalt_if_instr", if_instr, HALT);
    check("rehalt_if_valid", if_valid, 1);
    stall = 1'b1;
    step();
    stall = 1'b0;
    check("drain_stall_if_instr", if_instr, HALT);
    check("drain_stall_pc", pc, 29);
    step();
    check("rehalt_drain_valid", if_valid, 0);
    halt_ack = 1'b1;
    step();
    halt_ack = 1'b0;
    check("ack_halted", halted, 1);
    check("ack_if_valid", if_valid, 0);
    check("ack_pc", pc, 29);

    // Frozen: redirect and stall ignored
    redirect = 1'b1; redirect_pc = 8'd50;
    step();
    redirect = 1'b0;
    check("frz_redir_pc", pc, 29);
    check("frz_redir_halted", halted, 1);
    check("frz_redir_if_valid", if_valid, 0);
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    check("frz_pc", pc, 29);
    check("frz_halted", halted, 1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_halted", halted, 0);
    check("rst2_pc", pc, 1);
    check("rst2_if_valid", if_valid, 0);
    step();
    check("rst2_run_pc", pc, 2);
    check("rst2_run_if_pc", if_pc, 1);

    // Wrap-around at 255
    redirect = 1'b1; redirect_pc = 8'd255;
    step();
    redirect = 1'b0;
    check("wrap_pc255", pc, 255);
    step();
    check("wrap_pc0", pc, 0);
    check("wrap_if_pc", if_pc, 255);
    check("wrap_if_valid", if_valid, 1);
    check("wrap_if_instr", if_instr, rom[255]);
    step();
    check("wrap_pc1", pc, 1);
    check("wrap_if_pc0", if_pc, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
